// File: rtl/peak_average_tracker.sv
// Tracks per-window magnitude peaks over the last four windows and publishes
// their mean one cycle after every window end.
module peak_average_tracker #(
  parameter int unsigned WIN_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic [15:0]        Vt1,
  output logic [15:0]        Vt2,
  output logic [15:0]        Vt3,
  output logic [15:0]        Vt4,
  output logic [31:0]        MPavg,
  output logic               mp_valid,
  output logic               primed
);

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 16;
  localparam int unsigned SUMW = 18;
  localparam int unsigned FW   = 3;
  localparam logic [CW-1:0] LAST_IDX  = CW'(WIN_LEN - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(4);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_peak;
  logic [FW-1:0]   r_fill;
  logic            r_pend;
  logic [DW-1:0]   w_mag;
  logic [DW-1:0]   w_peak_final;
  logic            w_win_end;
  logic [SUMW-1:0] w_sum;

  // |sample_in|, with the one unrepresentable negative value saturated.
  always_comb begin
    w_mag = sample_in;
    if (sample_in[DW-1]) begin
      w_mag = (sample_in == 16'h8000) ? 16'h7FFF : DW'(~sample_in + 16'd1);
    end
  end

  assign w_peak_final = (w_mag > r_peak) ? w_mag : r_peak;
  assign w_win_end    = sample_valid && (r_cnt == LAST_IDX);
  assign w_sum        = SUMW'(Vt1) + SUMW'(Vt2) + SUMW'(Vt3) + SUMW'(Vt4);

  // FILL until the fourth window commits, then RUN until cleared.
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_FILL && w_win_end && r_fill == FW'(3)) begin
      w_state_next = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state  <= S_FILL;
      r_cnt    <= '0;
      r_peak   <= '0;
      r_fill   <= '0;
      r_pend   <= 1'b0;
      Vt1      <= '0;
      Vt2      <= '0;
      Vt3      <= '0;
      Vt4      <= '0;
      MPavg    <= '0;
      mp_valid <= 1'b0;
      primed   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pend   <= w_win_end;
      mp_valid <= r_pend;
      // Average is taken the edge after the history shift, from the new Vt*.
      if (r_pend) begin
        MPavg  <= 32'(w_sum >> 2);
        primed <= (r_state == S_RUN);
      end
      if (sample_valid) begin
        if (w_win_end) begin
          r_cnt  <= '0;
          r_peak <= '0;
          Vt4    <= Vt3;
          Vt3    <= Vt2;
          Vt2    <= Vt1;
          Vt1    <= w_peak_final;
          if (r_fill != FILL_FULL) begin
            r_fill <= r_fill + FW'(1);
          end
        end else begin
          r_cnt  <= r_cnt + CW'(1);
          r_peak <= w_peak_final;
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_average_tracker.sv
// Bench for peak_average_tracker (WIN_LEN=4): directed vector table, corner
// sequences and random traffic against a queue-based reference model.
module tb_peak_average_tracker;

  localparam int unsigned WIN = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] Vt1, Vt2, Vt3, Vt4;
  logic [31:0] MPavg;
  logic        mp_valid;
  logic        primed;

  peak_average_tracker #(.WIN_LEN(WIN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .Vt1(Vt1), .Vt2(Vt2), .Vt3(Vt3), .Vt4(Vt4),
    .MPavg(MPavg), .mp_valid(mp_valid), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: window history as a queue, newest first.
  int       m_hist[$];
  int       m_cnt, m_peak, m_wins;
  bit       m_pend, m_mpv, m_pr;
  int       m_avg;

  typedef struct {
    logic        r, f, v;
    logic [15:0] s;
    int          v1, v2, v3, v4, avg;
    logic        mpv, pr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mag_of(input logic [15:0] s);
    int x;
    x = int'($signed(s));
    if (x < 0) x = -x;
    if (x > 32767) x = 32767;
    return x;
  endfunction

  task automatic model_clear();
    m_hist = '{0, 0, 0, 0};
    m_cnt = 0; m_peak = 0; m_wins = 0;
    m_pend = 0; m_mpv = 0; m_pr = 0; m_avg = 0;
  endtask

  task automatic model_edge(input logic r, input logic f, input logic v, input logic [15:0] s);
    int sum;
    if (r || f) begin
      model_clear();
      return;
    end
    m_mpv = 0;
    if (m_pend) begin
      sum = 0;
      foreach (m_hist[i]) sum += m_hist[i];
      m_avg  = sum / 4;
      m_mpv  = 1;
      m_pr   = (m_wins >= 4);
      m_pend = 0;
    end
    if (v) begin
      if (mag_of(s) > m_peak) m_peak = mag_of(s);
      m_cnt++;
      if (m_cnt == WIN) begin
        m_hist.push_front(m_peak);
        void'(m_hist.pop_back());
        if (m_wins < 4) m_wins++;
        m_pend = 1;
        m_cnt  = 0;
        m_peak = 0;
      end
    end
  endtask

  task automatic model_cmp();
    chk("model_Vt1", 32'(Vt1), 32'(m_hist[0]));
    chk("model_Vt2", 32'(Vt2), 32'(m_hist[1]));
    chk("model_Vt3", 32'(Vt3), 32'(m_hist[2]));
    chk("model_Vt4", 32'(Vt4), 32'(m_hist[3]));
    chk("model_MPavg", MPavg, 32'(m_avg));
    chk("model_mp_valid", 32'(mp_valid), 32'(m_mpv));
    chk("model_primed", 32'(primed), 32'(m_pr));
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [15:0] s);
    rst = r; flush = f; sample_valid = v; sample_in = s;
    @(posedge clk);
    model_edge(r, f, v, s);
    #1;
    model_cmp();
  endtask

  task automatic add(input logic r, input logic f, input logic v, input int s,
                     input int v1, input int v2, input int v3, input int v4,
                     input int avg, input logic mpv, input logic pr);
    vec_t e;
    e.r = r; e.f = f; e.v = v; e.s = 16'(s);
    e.v1 = v1; e.v2 = v2; e.v3 = v3; e.v4 = v4; e.avg = avg; e.mpv = mpv; e.pr = pr;
    tbl.push_back(e);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; flush = 1'b0; sample_valid = 1'b0; sample_in = '0;
    model_clear();

    // Reset with valid traffic, then four windows (peaks 21,23,24,22), then a
    // flush two samples into a window and a fresh window counted from sample 1.
    add(1,0,1, 100,  0, 0, 0, 0,  0,0,0);
    add(1,0,0,   0,  0, 0, 0, 0,  0,0,0);
    add(0,0,1,   5,  0, 0, 0, 0,  0,0,0);
    add(0,0,1, -21,  0, 0, 0, 0,  0,0,0);
    add(0,0,1,   3,  0, 0, 0, 0,  0,0,0);
    add(0,0,1,   7, 21, 0, 0, 0,  0,0,0);
    add(0,0,1,  23, 21, 0, 0, 0,  5,1,0);
    add(0,0,1,   1, 21, 0, 0, 0,  5,0,0);
    add(0,0,1,   2, 21, 0, 0, 0,  5,0,0);
    add(0,0,1,  -3, 23,21, 0, 0,  5,0,0);
    add(0,0,1,  24, 23,21, 0, 0, 11,1,0);
    add(0,0,1,   0, 23,21, 0, 0, 11,0,0);
    add(0,0,1,   0, 23,21, 0, 0, 11,0,0);
    add(0,0,1,  -5, 24,23,21, 0, 11,0,0);
    add(0,0,1, -22, 24,23,21, 0, 17,1,0);
    add(0,0,1,   0, 24,23,21, 0, 17,0,0);
    add(0,0,1,   0, 24,23,21, 0, 17,0,0);
    add(0,0,1,   1, 22,24,23,21, 17,0,0);
    add(0,0,0,   0, 22,24,23,21, 22,1,1);
    add(0,0,0,   0, 22,24,23,21, 22,0,1);
    add(0,0,1,   9, 22,24,23,21, 22,0,1);
    add(0,0,1,   9, 22,24,23,21, 22,0,1);
    add(0,1,1,  50,  0, 0, 0, 0,  0,0,0);
    add(0,0,1,   3,  0, 0, 0, 0,  0,0,0);
    add(0,0,1,   4,  0, 0, 0, 0,  0,0,0);
    add(0,0,1,   5,  0, 0, 0, 0,  0,0,0);
    add(0,0,1,   6,  6, 0, 0, 0,  0,0,0);
    add(0,0,0,   0,  6, 0, 0, 0,  1,1,0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].s);
      chk($sformatf("tbl%0d_Vt1", i), 32'(Vt1), 32'(tbl[i].v1));
      chk($sformatf("tbl%0d_Vt2", i), 32'(Vt2), 32'(tbl[i].v2));
      chk($sformatf("tbl%0d_Vt3", i), 32'(Vt3), 32'(tbl[i].v3));
      chk($sformatf("tbl%0d_Vt4", i), 32'(Vt4), 32'(tbl[i].v4));
      chk($sformatf("tbl%0d_MPavg", i), MPavg, 32'(tbl[i].avg));
      chk($sformatf("tbl%0d_mpv", i), 32'(mp_valid), 32'(tbl[i].mpv));
      chk($sformatf("tbl%0d_primed", i), 32'(primed), 32'(tbl[i].pr));
    end

    // Saturating magnitude, then an all-zero window.
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h8000);
    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    chk("sat_Vt1", 32'(Vt1), 32'd32767);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0);
    chk("zero_Vt1", 32'(Vt1), 32'd0);
    chk("zero_Vt2", 32'(Vt2), 32'd32767);

    // Idle gaps between valid samples: exactly one window end.
    step(0, 1, 0, 16'h0);
    pulses = 0;
    begin
      logic [15:0] seq [4];
      seq[0] = 16'd1; seq[1] = 16'd9; seq[2] = 16'd2; seq[3] = 16'd4;
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 1, seq[i]);
        if (mp_valid) pulses++;
        if (i < 3) begin
          for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 16'h0);
            if (mp_valid) pulses++;
          end
        end
      end
    end
    chk("gap_Vt1", 32'(Vt1), 32'd9);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 16'h0);
      if (mp_valid) pulses++;
    end
    chk("gap_pulses", 32'(pulses), 32'd1);
    chk("gap_MPavg", MPavg, 32'd2);

    // Reset on E+1 cancels the pending average.
    step(0, 1, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'd40);
    chk("e1_Vt1", 32'(Vt1), 32'd40);
    step(1, 0, 1, 16'd7);
    step(0, 0, 0, 16'h0);
    chk("e1_mpv", 32'(mp_valid), 32'd0);
    chk("e1_MPavg", MPavg, 32'd0);

    // Random traffic with occasional rst/flush and -32768 samples.
    for (int n = 0; n < 3000; n++) begin
      logic r, f, v;
      logic [15:0] s;
      r = ($urandom_range(0, 299) == 0);
      f = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 19) == 0) ? 16'h8000 : 16'($urandom);
      step(r, f, v, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
